// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_pkg
//  Description : Shared state encoding and width helper for the sequential
//                restoring divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int C_DEF_M = 8;
    localparam int C_DEF_N = 8;

    // Dividend/quotient width matches the MAC accumulator output
    function automatic int width_w(input int m, input int n);
        return m + n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_if
//  Description : start/busy/done handshake and operand/result bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int M = C_DEF_M,
    parameter int N = C_DEF_N
);
    localparam int W = width_w(M, N);

    logic         start;
    logic [W-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [N-1:0] remainder;
    logic         dbz;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, dbz
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, dbz
    );

endinterface
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_div_step
//  Description : One combinational restoring-division iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_div_step #(
    parameter int N = 8
) (
    input  wire logic [N-1:0] i_pr,
    input  wire logic         i_bit,
    input  wire logic [N-1:0] i_divisor,
    output logic      [N-1:0] o_pr,
    output logic              o_qbit
);

    logic [N:0] w_shift;

    assign w_shift = {i_pr, i_bit};
    assign o_qbit  = (w_shift >= {1'b0, i_divisor});

    // The restored value is always below the divisor, so N-bit wraparound
    // subtraction yields the exact result and the carry bit can be dropped.
    assign o_pr = o_qbit ? (w_shift[N-1:0] - i_divisor) : w_shift[N-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Sequential restoring divider, one quotient bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int M = C_DEF_M,
    parameter int N = C_DEF_N
) (
    input  wire logic    clk,
    input  wire logic    rst,
    seq_divider_if.slave bus
);

    localparam int              W      = width_w(M, N);
    localparam int              CW     = $clog2(W + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(W - 1);

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_dq;
    logic [N-1:0]    r_dvs;
    logic [N-1:0]    r_pr;
    logic [CW-1:0]   r_cnt;
    logic [W-1:0]    r_quotient;
    logic [N-1:0]    r_remainder;
    logic            r_dbz;
    logic [N-1:0]    w_pr;
    logic            w_qbit;
    logic            w_last;

    assign w_last = (r_cnt == C_LAST);

    seq_divider_div_step #(
        .N (N)
    ) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_dq[W-1]),
        .i_divisor (r_dvs),
        .o_pr      (w_pr),
        .o_qbit    (w_qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) w_next = (bus.divisor != '0) ? ST_RUN : ST_DONE;
            end
            ST_RUN: begin
                if (w_last) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // r_dq starts as the dividend and fills with quotient bits from the LSB
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dq        <= '0;
            r_dvs       <= '0;
            r_pr        <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor != '0) begin
                            r_dq  <= bus.dividend;
                            r_dvs <= bus.divisor;
                            r_pr  <= '0;
                            r_cnt <= '0;
                        end else begin
                            r_quotient  <= '1;
                            r_remainder <= '0;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_dq  <= {r_dq[W-2:0], w_qbit};
                    r_pr  <= w_pr;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_quotient  <= {r_dq[W-2:0], w_qbit};
                        r_remainder <= w_pr;
                        r_dbz       <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (r_state == ST_RUN);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.dbz       = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_divider
//  Description : Self-checking bench for seq_divider with a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    localparam int W = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    seq_divider_if #(.M(8), .N(8)) bus ();

    seq_divider #(.M(8), .N(8)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_q(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 16'hFFFF;
        return a / {8'd0, b};
    endfunction

    function automatic logic [7:0] ref_r(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 8'd0;
        return 8'(a % {8'd0, b});
    endfunction

    // One full operation: latency, busy length, results, single-cycle done
    task automatic do_div(input logic [15:0] a, input logic [7:0] b, input string name);
        int cyc;
        int busy_cnt;
        int exp_lat;
        int exp_busy;
        exp_lat  = (b == 8'd0) ? 1 : W + 1;
        exp_busy = (b == 8'd0) ? 0 : W;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
        @(negedge clk);
        bus.start = 1'b0; bus.dividend = 16'($urandom); bus.divisor = 8'($urandom);
        cyc = 1; busy_cnt = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles expected %0d", name, cyc, exp_lat);
        end
        checks++;
        if (busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s busy length: got %0d expected %0d", name, busy_cnt, exp_busy);
        end
        checks++;
        if (bus.quotient !== ref_q(a, b)) begin
            errors++;
            $display("FAIL %s quotient: got %0d expected %0d", name, bus.quotient, ref_q(a, b));
        end
        checks++;
        if (bus.remainder !== ref_r(a, b)) begin
            errors++;
            $display("FAIL %s remainder: got %0d expected %0d", name, bus.remainder, ref_r(a, b));
        end
        checks++;
        if (bus.dbz !== (b == 8'd0)) begin
            errors++;
            $display("FAIL %s dbz: got %0b expected %0b", name, bus.dbz, (b == 8'd0));
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s done pulse width: done still %0b", name, bus.done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.dbz} !== 3'b000) begin
            errors++;
            $display("FAIL reset flags: got busy/done/dbz=%b expected 000", {bus.busy, bus.done, bus.dbz});
        end
        checks++;
        if (bus.quotient !== 16'd0 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL reset results: got q=%0d r=%0d expected 0/0", bus.quotient, bus.remainder);
        end
        rst = 1'b1;
    endtask

    task automatic test_directed();
        do_div(16'd1000,  8'd7,   "1000/7");
        do_div(16'd65535, 8'd255, "65535/255");
        do_div(16'd65535, 8'd1,   "65535/1");
        do_div(16'd5,     8'd9,   "5/9");
        do_div(16'd0,     8'd3,   "0/3");
        do_div(16'd1234,  8'd0,   "1234/0");
        do_div(16'd100,   8'd10,  "100/10");
    endtask

    task automatic test_random();
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 25; i++) begin
            a = (i % 4 == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            do_div(a, b, "random");
        end
    endtask

    // Start attempts during RUN and DONE are ignored; held start re-arms in IDLE
    task automatic test_ignored_start();
        int cyc;
        int first_done;
        int second_done;
        first_done = 0; second_done = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
        cyc = 0;
        while (second_done == 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.done) begin
                if (first_done == 0) begin
                    first_done = cyc;
                    checks++;
                    if (bus.quotient !== 16'd142 || bus.remainder !== 8'd6) begin
                        errors++;
                        $display("FAIL ignored start result: got %0d r %0d expected 142 r 6", bus.quotient, bus.remainder);
                    end
                end else begin
                    second_done = cyc;
                    checks++;
                    if (bus.quotient !== 16'd10 || bus.remainder !== 8'd0) begin
                        errors++;
                        $display("FAIL held start result: got %0d r %0d expected 10 r 0", bus.quotient, bus.remainder);
                    end
                end
            end
            bus.start = (cyc == 5) || (cyc >= 10 && second_done == 0);
            if (cyc == 5) begin
                bus.dividend = 16'd50; bus.divisor = 8'd5;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (first_done !== W + 1) begin
            errors++;
            $display("FAIL ignored start latency: got %0d expected %0d", first_done, W + 1);
        end
        checks++;
        if (second_done - first_done !== W + 2) begin
            errors++;
            $display("FAIL back to back spacing: got %0d expected %0d", second_done - first_done, W + 2);
        end
    endtask

    task automatic test_reset_mid();
        int done_seen;
        done_seen = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 16'd1000; bus.divisor = 8'd7;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) done_seen++;
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.dbz} !== 3'b000) begin
            errors++;
            $display("FAIL mid reset flags: got busy/done/dbz=%b expected 000", {bus.busy, bus.done, bus.dbz});
        end
        checks++;
        if (bus.quotient !== 16'd0 || bus.remainder !== 8'd0) begin
            errors++;
            $display("FAIL mid reset results: got q=%0d r=%0d expected 0/0", bus.quotient, bus.remainder);
        end
        repeat (3) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        rst = 1'b1;
        repeat (W + 4) begin
            @(negedge clk);
            if (bus.done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            errors++;
            $display("FAIL mid reset done pulses: got %0d expected 0", done_seen);
        end
        do_div(16'd200, 8'd3, "200/3 after reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignored_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
